// File: rtl/dut_bus_source.sv
// dut_bus_source: memory-mapped byte FIFO that buffers bytes offered by a host
// and hands them to a CPU through a DATA/STATUS register pair.
//   addr[2]=0 : DATA   (read pops the head byte; writes ignored)
//   addr[2]=1 : STATUS (read) / CTRL (write: wd[0]=flush, wd[1]=irq_en)
// Optional feature: define DUT_BUS_SOURCE_IRQ_EN to add the irq port and the
// irq_en control bit. Without it the block has no interrupt and wd[1] is inert.
//
// Host handshake: a byte transfers on a rising edge where in_valid && in_ready
// are both high. in_ready is !full and depends only on registered state. Once
// in_valid is raised the host keeps in_valid/in_data stable until accepted.
module dut_bus_source #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] addr,
    input  logic        re,
    output logic [31:0] rd,
    input  logic        we,
    input  logic [31:0] wd,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready
`ifdef DUT_BUS_SOURCE_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          ctrl_wr;
    logic          flush;
    logic          irq_en;

    // Only addr[2] is decoded; the upper address bits and unused write bits
    // are deliberately dropped here.
    logic unused_bits;
    assign unused_bits = &{1'b0, addr[31:3], wd[31:1]};

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign in_ready = !full;

    // A pop only happens on a DATA read with something to return; a read of an
    // empty FIFO returns zero and leaves the state alone, even if a push lands
    // in the same cycle.
    assign push    = in_valid && in_ready;
    assign pop     = re && !addr[2] && !empty;
    assign ctrl_wr = we && addr[2];
    assign flush   = ctrl_wr && wd[0];

    // Pointer and occupancy tracking; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; a byte discarded by flush or reset is simply not written.
    always_ff @(posedge clk) begin
        if (reset && push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

`ifdef DUT_BUS_SOURCE_IRQ_EN
    // Interrupt enable is loaded by every CTRL write, including flushes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_en <= 1'b0;
        end else if (ctrl_wr) begin
            irq_en <= wd[1];
        end
    end

    // Level interrupt built from registered state only.
    assign irq = irq_en && !empty;
`else
    assign irq_en = 1'b0;
`endif

    // Read mux: combinational, zero whenever no read strobe is present.
    always_comb begin
        rd = 32'h0;
        if (re) begin
            if (addr[2]) begin
                rd = {7'b0, irq_en, 6'b0, full, empty, 16'(count)};
            end else if (!empty) begin
                rd = {1'b1, 23'b0, mem[rd_ptr]};
            end
        end
    end

endmodule

// File: doc/dut_bus_source.md
DUT_BUS_SOURCE -- requirements
Module: dut_bus_source

Interface
REQ-001 Parameter: DEPTH, default 16, FIFO depth in bytes; power of two, 2..256.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset.
REQ-004 Port: addr  input  30 [31:2]  word address from mmu; only addr[2] decoded (0=DATA, 1=STATUS/CTRL).
REQ-005 Port: re  input  1  read strobe, one cycle per CPU load.
REQ-006 Port: rd  output  32  read data, combinational from addr/re/state.
REQ-007 Port: we  input  1  write strobe, one cycle per CPU store.
REQ-008 Port: wd  input  32  write data.
REQ-009 Port: in_valid  input  1  host byte offered.
REQ-010 Port: in_data  input  8  host byte.
REQ-011 Port: in_ready  output  1  block accepts byte; equals !full.
REQ-012 Port: irq  output  1  level interrupt; present only with DUT_BUS_SOURCE_IRQ_EN.

Function
REQ-013 Byte FIFO of DEPTH entries: rd/wr pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
REQ-014 Push: in_valid && in_ready at clock edge writes in_data at wr pointer, pointer +1.
REQ-015 DATA read (re, addr[2]=0), non-empty: rd = {1'b1, 23'b0, head byte}; head popped at the same edge.
REQ-016 DATA read when empty: rd = 32'h0; no pointer or count change.
REQ-017 STATUS read (re, addr[2]=1): rd[15:0]=count, rd[16]=empty, rd[17]=full, rd[24]=irq_en (0 without macro), others 0.
REQ-018 rd = 32'h0 whenever re=0.
REQ-019 Push and pop in the same cycle: both occur, count unchanged; on empty FIFO only the push occurs (read returns 0).
REQ-020 Full: in_ready=0, host holds in_valid/in_data until accepted; no byte lost or overwritten.
REQ-021 CTRL write (we, addr[2]=1): wd[0]=1 flushes (pointers and count to 0); wd[1] loads irq_en.
REQ-022 Flush and push in the same cycle: flush wins, pushed byte discarded, FIFO empty afterwards.
REQ-023 Writes to DATA (addr[2]=0) ignored.
REQ-024 Simultaneous re and we: both take effect; read uses pre-edge state.

Reset
REQ-025 reset=0 at an edge: pointers, count and irq_en cleared; in_ready=1, irq=0, rd=0 with re=0.
REQ-026 Reset dominates push, pop and CTRL write in the same cycle; FIFO contents after reset undefined and unobservable.
REQ-027 Reset mid-stream: all buffered bytes discarded; first post-reset push lands at entry 0.

Configuration
REQ-028 Macro DUT_BUS_SOURCE_IRQ_EN defined: irq port and irq_en bit exist; irq = irq_en && !empty, registered-state only (no combinational path from re/we).
REQ-029 Macro undefined: no irq port; wd[1] ignored; STATUS rd[24]=0.

Verification
REQ-030 Push 0x68,0x65,0x6c; three DATA reads -> 0x8000_0068, 0x8000_0065, 0x8000_006c; fourth read -> 0x0.
REQ-031 DEPTH=16, host pushes 20 bytes continuously -> in_ready low after 16th; STATUS = 0x0002_0010; 20 DATA reads return all 20 in order.
REQ-032 Count=5, push and DATA read in same cycle -> count stays 5, read returns oldest byte.
REQ-033 Count=3, CTRL write 0x1 concurrent with push -> STATUS = 0x0001_0000, next DATA read 0x0.
REQ-034 Count=7, reset=0 one cycle -> STATUS 0x0001_0000, in_ready=1; wr/rd pointers wrap correctly over 40 subsequent bytes.
REQ-035 IRQ_EN build: CTRL write 0x2, push 0xAA -> irq=1 next cycle; DATA read -> 0x8000_00AA, irq=0 following cycle.
